// File: rtl/mac_window_packer_if.sv
// Stream and status bundle for the MAC window packer.
// The master modport is the producer/consumer side; the slave modport is the packer itself.
interface mac_window_packer_if #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_INPUTS = 27
);
    logic                               start;
    logic                               in_valid;
    logic                               in_ready;
    logic signed [DATA_WIDTH-1:0]       pixel_in;
    logic signed [DATA_WIDTH-1:0]       weight_in;
    logic [NUM_INPUTS*DATA_WIDTH-1:0]   packed_out;
    logic                               data_valid_out;
    logic                               end_flag;
    logic                               busy;

    modport master (
        output start, in_valid, pixel_in, weight_in,
        input  in_ready, packed_out, data_valid_out, end_flag, busy
    );

    modport slave (
        input  start, in_valid, pixel_in, weight_in,
        output in_ready, packed_out, data_valid_out, end_flag, busy
    );
endinterface

// File: rtl/mac_window_packer.sv
// Multiplies pixel/weight pairs, rounds half-to-even, saturates and packs NUM_INPUTS
// results per window; signals end of run after DRAIN_CYCLES (must be >= 1).
module mac_window_packer #(
    parameter int DATA_WIDTH   = 14,
    parameter int FRAC_WIDTH   = 8,
    parameter int NUM_INPUTS   = 27,
    parameter int NUM_WINDOWS  = 16,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mac_window_packer_if.slave    bus
);

    localparam int PROD_W  = 2 * DATA_WIDTH;
    localparam int PACK_W  = NUM_INPUTS * DATA_WIDTH;
    localparam int ELEM_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int WIN_W   = 16;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [ELEM_W-1:0]       LAST_ELEM  = ELEM_W'(NUM_INPUTS - 1);
    localparam logic [WIN_W-1:0]        LAST_WIN   = WIN_W'(NUM_WINDOWS - 1);
    localparam logic [DRAIN_W-1:0]      LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [FRAC_WIDTH-1:0]   HALF       = FRAC_WIDTH'(1 << (FRAC_WIDTH - 1));
    localparam logic signed [PROD_W-1:0] SAT_MAX   = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ELEM_W-1:0]    elemCnt_q, elemCnt_d;
    logic [WIN_W-1:0]     winCnt_q, winCnt_d;
    logic [DRAIN_W-1:0]   drainCnt_q, drainCnt_d;
    logic [PACK_W-1:0]    work_q, work_d;
    logic [PACK_W-1:0]    packed_q, packed_d;
    logic                 dataValid_q, dataValid_d;

    logic signed [PROD_W-1:0] pixExt;
    logic signed [PROD_W-1:0] wtExt;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] floorQ;
    logic signed [PROD_W-1:0] rounded;
    logic [FRAC_WIDTH-1:0]    remBits;
    logic                     roundUp;
    logic [DATA_WIDTH-1:0]    elemVal;

    // Full-precision product, arithmetic shift (floor), then nudge up on
    // fractions above one half or on an exact half with an odd quotient.
    always_comb begin
        pixExt  = $signed({{DATA_WIDTH{bus.pixel_in[DATA_WIDTH-1]}}, bus.pixel_in});
        wtExt   = $signed({{DATA_WIDTH{bus.weight_in[DATA_WIDTH-1]}}, bus.weight_in});
        product = pixExt * wtExt;
        floorQ  = product >>> FRAC_WIDTH;
        remBits = product[FRAC_WIDTH-1:0];
        roundUp = (remBits > HALF) || ((remBits == HALF) && floorQ[0]);
        rounded = floorQ + PROD_W'(roundUp);
        if (rounded > SAT_MAX) begin
            elemVal = SAT_MAX[DATA_WIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            elemVal = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            elemVal = rounded[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        elemCnt_d   = elemCnt_q;
        winCnt_d    = winCnt_q;
        drainCnt_d  = drainCnt_q;
        work_d      = work_q;
        packed_d    = packed_q;
        dataValid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = FILL;
                    elemCnt_d = '0;
                    winCnt_d  = '0;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < NUM_INPUTS; k++) begin
                        if (ELEM_W'(k) == elemCnt_q) begin
                            work_d[k*DATA_WIDTH +: DATA_WIDTH] = elemVal;
                        end
                    end
                    // The output register only changes here, so a partial
                    // window never disturbs what downstream is reading.
                    if (elemCnt_q == LAST_ELEM) begin
                        elemCnt_d   = '0;
                        packed_d    = work_d;
                        dataValid_d = 1'b1;
                        winCnt_d    = winCnt_q + WIN_W'(1);
                        if (winCnt_q == LAST_WIN) begin
                            state_d    = DRAIN;
                            drainCnt_d = '0;
                        end
                    end else begin
                        elemCnt_d = elemCnt_q + ELEM_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drainCnt_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drainCnt_d = drainCnt_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            elemCnt_q   <= '0;
            winCnt_q    <= '0;
            drainCnt_q  <= '0;
            work_q      <= '0;
            packed_q    <= '0;
            dataValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            elemCnt_q   <= elemCnt_d;
            winCnt_q    <= winCnt_d;
            drainCnt_q  <= drainCnt_d;
            work_q      <= work_d;
            packed_q    <= packed_d;
            dataValid_q <= dataValid_d;
        end
    end

    assign bus.in_ready       = (state_q == FILL);
    assign bus.busy           = (state_q != IDLE);
    assign bus.end_flag       = (state_q == DONE);
    assign bus.data_valid_out = dataValid_q;
    assign bus.packed_out     = packed_q;

endmodule

// File: tb/tb_mac_window_packer.sv
// Bench for mac_window_packer: a one-window and a three-window instance share one
// stimulus stream and are compared against a real-arithmetic reference model.
module tb_mac_window_packer;

    localparam int  DW    = 14;
    localparam int  FW    = 8;
    localparam int  NI    = 27;
    localparam int  NW_B  = 3;
    localparam int  DRAIN = 8;
    localparam int  PW    = NI * DW;
    localparam int  TOTAL = NI * NW_B;
    localparam real SCALE = 256.0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic inValid = 1'b0;
    logic signed [DW-1:0] pixelIn = '0;
    logic signed [DW-1:0] weightIn = '0;

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;
    int missA = 0;
    int missB = 0;
    int overlapB = 0;
    int lastXfer = 0;

    int dvCycA[$];
    int dvCycB[$];
    int efCycA[$];
    int efCycB[$];
    logic [PW-1:0] dvDatA[$];
    logic [PW-1:0] dvDatB[$];

    int pixArr[TOTAL];
    int wtArr[TOTAL];
    logic [PW-1:0] goldStream[NW_B];

    mac_window_packer_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) ifA ();
    mac_window_packer_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) ifB ();

    assign ifA.start     = start;
    assign ifA.in_valid  = inValid;
    assign ifA.pixel_in  = pixelIn;
    assign ifA.weight_in = weightIn;
    assign ifB.start     = start;
    assign ifB.in_valid  = inValid;
    assign ifB.pixel_in  = pixelIn;
    assign ifB.weight_in = weightIn;

    mac_window_packer #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .NUM_INPUTS(NI),
                        .NUM_WINDOWS(1), .DRAIN_CYCLES(DRAIN))
        dutA (.clk(clk), .reset(reset), .bus(ifA.slave));

    mac_window_packer #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .NUM_INPUTS(NI),
                        .NUM_WINDOWS(NW_B), .DRAIN_CYCLES(DRAIN))
        dutB (.clk(clk), .reset(reset), .bus(ifB.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (ifA.data_valid_out) begin
            dvCycA.push_back(cyc);
            dvDatA.push_back(ifA.packed_out);
        end
        if (ifA.end_flag) efCycA.push_back(cyc);
        if (ifB.data_valid_out) begin
            dvCycB.push_back(cyc);
            dvDatB.push_back(ifB.packed_out);
        end
        if (ifB.end_flag) efCycB.push_back(cyc);
        if (ifB.end_flag && ifB.data_valid_out) overlapB++;
    end

    function automatic int refProduct(input int p, input int w);
        real x;
        real fl;
        int  r;
        x  = real'(p * w) / SCALE;
        fl = $floor(x);
        r  = int'(fl);
        if (x - fl > 0.5) r++;
        else if ((x - fl == 0.5) && (r % 2 != 0)) r++;
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        return r;
    endfunction

    function automatic logic [PW-1:0] refWindow(input int base);
        logic [PW-1:0] v;
        int e;
        v = '0;
        for (int k = 0; k < NI; k++) begin
            e = refProduct(pixArr[base + k], wtArr[base + k]);
            v[k*DW +: DW] = e[DW-1:0];
        end
        return v;
    endfunction

    task automatic clearLogs();
        dvCycA.delete(); dvCycB.delete(); efCycA.delete(); efCycB.delete();
        dvDatA.delete(); dvDatB.delete();
        missA = 0; missB = 0; overlapB = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; inValid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clearLogs();
    endtask

    task automatic driveCycle(input bit v, input int p, input int w, input bit s);
        @(negedge clk);
        inValid  = v;
        pixelIn  = DW'(p);
        weightIn = DW'(w);
        start    = s;
        if (v && !ifA.in_ready) missA++;
        if (v && !ifB.in_ready) missB++;
    endtask

    task automatic randomFill();
        for (int i = 0; i < TOTAL; i++) begin
            pixArr[i] = int'($urandom_range(0, 16383)) - 8192;
            wtArr[i]  = int'($urandom_range(0, 16383)) - 8192;
        end
    endtask

    task automatic sendElems(input int count, input bit gaps, input bit startNoise);
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                int idle = int'($urandom_range(0, 3));
                for (int j = 0; j < idle; j++)
                    driveCycle(1'b0, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
                               startNoise && ($urandom_range(0, 1) == 1));
            end
            driveCycle(1'b1, pixArr[i], wtArr[i], startNoise && ($urandom_range(0, 3) == 0));
            lastXfer = cyc;
        end
        driveCycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nChecks++; if (ifA.packed_out !== '0) begin nFails++; $display("[TB] FAIL reset_packedA: got %h expected 0", ifA.packed_out); end
        nChecks++; if (ifB.packed_out !== '0) begin nFails++; $display("[TB] FAIL reset_packedB: got %h expected 0", ifB.packed_out); end
        nChecks++; if ({ifA.data_valid_out, ifA.end_flag, ifA.busy, ifA.in_ready} !== 4'b0) begin
            nFails++; $display("[TB] FAIL reset_flagsA: got %b expected 0000", {ifA.data_valid_out, ifA.end_flag, ifA.busy, ifA.in_ready}); end
        nChecks++; if ({ifB.data_valid_out, ifB.end_flag, ifB.busy, ifB.in_ready} !== 4'b0) begin
            nFails++; $display("[TB] FAIL reset_flagsB: got %b expected 0000", {ifB.data_valid_out, ifB.end_flag, ifB.busy, ifB.in_ready}); end
        reset = 1'b1;
        clearLogs();
    endtask

    task automatic test_single_window();
        logic [PW-1:0] expWin;
        int dv0;
        $display("[TB] single window");
        doReset();
        for (int i = 0; i < NI; i++) begin pixArr[i] = 256; wtArr[i] = 256; end
        expWin = {NI{14'h0100}};
        driveCycle(1'b0, 0, 0, 1'b1);
        sendElems(NI, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        dv0 = (dvCycA.size() > 0) ? dvCycA[0] : -1;
        nChecks++; if (dvCycA.size() != 1) begin nFails++; $display("[TB] FAIL single_dv_count: got %0d expected 1", dvCycA.size()); end
        nChecks++; if (dv0 != lastXfer + 1) begin nFails++; $display("[TB] FAIL single_dv_latency: got cycle %0d expected %0d", dv0, lastXfer + 1); end
        nChecks++; if (((dvDatA.size() > 0) ? dvDatA[0] : '0) !== expWin) begin
            nFails++; $display("[TB] FAIL single_packed: got %h expected %h", (dvDatA.size() > 0) ? dvDatA[0] : '0, expWin); end
        nChecks++; if (efCycA.size() != 1 || efCycA[0] != dv0 + DRAIN) begin
            nFails++; $display("[TB] FAIL single_end_flag: got %0d pulses first at %0d expected 1 at %0d",
                               efCycA.size(), (efCycA.size() > 0) ? efCycA[0] : -1, dv0 + DRAIN); end
        nChecks++; if (ifA.busy !== 1'b0 || missA != 0) begin nFails++; $display("[TB] FAIL single_busy_after: got busy %b misses %0d expected 0 0", ifA.busy, missA); end
        nChecks++; if (ifA.packed_out !== expWin) begin nFails++; $display("[TB] FAIL single_hold: got %h expected %h", ifA.packed_out, expWin); end
    endtask

    task automatic test_rounding_saturation();
        int tieP[7] = '{1, 3, -1, -3, 8191, -8192, -8192};
        int tieW[7] = '{128, 128, 128, 128, 8191, 8191, -8192};
        int tieE[7] = '{0, 2, 0, -2, 8191, -8192, 8191};
        logic [PW-1:0] gotWin;
        logic signed [DW-1:0] slotVal;
        $display("[TB] rounding and saturation");
        doReset();
        randomFill();
        for (int k = 0; k < 7; k++) begin pixArr[k] = tieP[k]; wtArr[k] = tieW[k]; end
        driveCycle(1'b0, 0, 0, 1'b1);
        sendElems(NI, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        gotWin = (dvDatB.size() > 0) ? dvDatB[0] : '0;
        for (int k = 0; k < 7; k++) begin
            slotVal = gotWin[k*DW +: DW];
            nChecks++;
            if (int'(slotVal) != tieE[k]) begin
                nFails++; $display("[TB] FAIL round_sat_slot%0d: got %0d expected %0d", k, int'(slotVal), tieE[k]);
            end
        end
        nChecks++; if (gotWin !== refWindow(0)) begin nFails++; $display("[TB] FAIL round_sat_window: got %h expected %h", gotWin, refWindow(0)); end
    endtask

    task automatic test_streaming();
        logic [PW-1:0] expWin;
        logic [PW-1:0] gotWin;
        $display("[TB] back-to-back streaming");
        doReset();
        randomFill();
        driveCycle(1'b0, 0, 0, 1'b1);
        sendElems(TOTAL, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        nChecks++; if (dvCycB.size() != NW_B) begin nFails++; $display("[TB] FAIL stream_dv_count: got %0d expected %0d", dvCycB.size(), NW_B); end
        for (int w = 0; w < NW_B; w++) begin
            expWin = refWindow(w * NI);
            gotWin = (dvDatB.size() > w) ? dvDatB[w] : '0;
            goldStream[w] = gotWin;
            nChecks++;
            if (gotWin !== expWin) begin nFails++; $display("[TB] FAIL stream_window%0d: got %h expected %h", w, gotWin, expWin); end
        end
        if (dvCycB.size() == NW_B) begin
            nChecks++; if (dvCycB[1] - dvCycB[0] != NI || dvCycB[2] - dvCycB[1] != NI) begin
                nFails++; $display("[TB] FAIL stream_spacing: got %0d %0d expected %0d", dvCycB[1] - dvCycB[0], dvCycB[2] - dvCycB[1], NI); end
            nChecks++; if (efCycB.size() != 1 || efCycB[0] != dvCycB[2] + DRAIN) begin
                nFails++; $display("[TB] FAIL stream_end_flag: got %0d pulses first at %0d expected 1 at %0d",
                                   efCycB.size(), (efCycB.size() > 0) ? efCycB[0] : -1, dvCycB[2] + DRAIN); end
        end
        nChecks++; if (missB != 0 || overlapB != 0) begin nFails++; $display("[TB] FAIL stream_ready_overlap: got %0d %0d expected 0 0", missB, overlapB); end
        nChecks++; if (((dvDatA.size() > 0) ? dvDatA[0] : '0) !== refWindow(0) || dvCycA.size() != 1) begin
            nFails++; $display("[TB] FAIL stream_single_instance: got %0d windows first %h expected 1 %h",
                               dvCycA.size(), (dvDatA.size() > 0) ? dvDatA[0] : '0, refWindow(0)); end
    endtask

    task automatic test_stalls_and_start();
        logic [PW-1:0] gotWin;
        $display("[TB] stalls with stray start");
        doReset();
        driveCycle(1'b0, 0, 0, 1'b1);
        sendElems(TOTAL, 1'b1, 1'b1);
        repeat (14) @(negedge clk);
        nChecks++; if (dvCycB.size() != NW_B) begin nFails++; $display("[TB] FAIL stall_dv_count: got %0d expected %0d", dvCycB.size(), NW_B); end
        for (int w = 0; w < NW_B; w++) begin
            gotWin = (dvDatB.size() > w) ? dvDatB[w] : '0;
            nChecks++;
            if (gotWin !== goldStream[w] || gotWin !== refWindow(w * NI)) begin
                nFails++; $display("[TB] FAIL stall_window%0d: got %h expected %h", w, gotWin, refWindow(w * NI)); end
        end
        nChecks++; if (efCycB.size() != 1 || ifB.busy !== 1'b0) begin
            nFails++; $display("[TB] FAIL stall_end: got %0d pulses busy %b expected 1 pulse busy 0", efCycB.size(), ifB.busy); end
    endtask

    task automatic test_reset_midop();
        logic [PW-1:0] gotWin;
        $display("[TB] reset mid-window and mid-drain");
        randomFill();
        driveCycle(1'b0, 0, 0, 1'b1);
        sendElems(10, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        nChecks++; if (ifB.packed_out !== '0) begin nFails++; $display("[TB] FAIL midreset_packed: got %h expected 0", ifB.packed_out); end
        nChecks++; if ({ifB.data_valid_out, ifB.end_flag, ifB.busy, ifB.in_ready} !== 4'b0) begin
            nFails++; $display("[TB] FAIL midreset_flags: got %b expected 0000", {ifB.data_valid_out, ifB.end_flag, ifB.busy, ifB.in_ready}); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clearLogs();
        randomFill();
        driveCycle(1'b0, 0, 0, 1'b1);
        sendElems(TOTAL, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        for (int w = 0; w < NW_B; w++) begin
            gotWin = (dvDatB.size() > w) ? dvDatB[w] : '0;
            nChecks++;
            if (gotWin !== refWindow(w * NI)) begin nFails++; $display("[TB] FAIL rerun_window%0d: got %h expected %h", w, gotWin, refWindow(w * NI)); end
        end
        nChecks++; if (dvCycB.size() != NW_B || efCycB.size() != 1) begin
            nFails++; $display("[TB] FAIL rerun_pulses: got %0d dv %0d end expected %0d 1", dvCycB.size(), efCycB.size(), NW_B); end
        driveCycle(1'b0, 0, 0, 1'b1);
        sendElems(TOTAL, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clearLogs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        nChecks++; if (efCycB.size() != 0 || dvCycB.size() != 0 || ifB.busy !== 1'b0) begin
            nFails++; $display("[TB] FAIL drainreset_suppress: got %0d end %0d dv busy %b expected 0 0 0", efCycB.size(), dvCycB.size(), ifB.busy); end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_rounding_saturation();
        test_streaming();
        test_stalls_and_start();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mac_window_packer.md
MAC_WINDOW_PACKER -- requirements
Module: mac_window_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 14: width of each signed fixed-point element (Q6.8).
REQ-002 Parameter FRAC_WIDTH, default 8: fractional bits of pixel, weight and packed element.
REQ-003 Parameter NUM_INPUTS, default 27: elements per window (3x3x3 kernel).
REQ-004 Parameter NUM_WINDOWS, default 16: windows per run; range 1..65535.
REQ-005 Parameter DRAIN_CYCLES, default 8: cycles between the last data_valid_out and end_flag.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  single-cycle pulse that begins a run; sampled only in IDLE.
REQ-009 in_valid  input  1  pixel_in and weight_in are valid this cycle.
REQ-010 in_ready  output  1  block accepts an element this cycle.
REQ-011 pixel_in  input  DATA_WIDTH  signed activation, Q6.8.
REQ-012 weight_in  input  DATA_WIDTH  signed weight, Q6.8.
REQ-013 packed_out  output  NUM_INPUTS*DATA_WIDTH  packed signed products; element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 data_valid_out  output  1  one-cycle pulse marking a complete packed_out window.
REQ-015 end_flag  output  1  one-cycle pulse marking end of run, for the downstream adder tree.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, FILL, DRAIN and DONE.
REQ-018 IDLE->FILL SHALL occur on start=1; start outside IDLE SHALL be ignored.
REQ-019 in_ready SHALL be 1 in FILL only; a transfer SHALL occur when in_valid and in_ready are both 1, and in_valid SHALL be ignored in every other state.
REQ-020 Each transfer SHALL form the full-precision signed product pixel_in*weight_in (2*DATA_WIDTH bits, 2*FRAC_WIDTH fraction).
REQ-021 The product SHALL be shifted right by FRAC_WIDTH with round-half-to-even.
REQ-022 The rounded product SHALL be saturated to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-023 The saturated result SHALL be written into slot elem_cnt of a working register, and elem_cnt SHALL then increment.
REQ-024 On the transfer with elem_cnt=NUM_INPUTS-1, packed_out SHALL load the working register with the new element in the top slot.
REQ-025 On that same transfer, elem_cnt SHALL wrap to 0.
REQ-026 data_valid_out SHALL be 1 for exactly the one cycle following that edge (latency 1 cycle from the last accepted element).
REQ-027 packed_out SHALL hold its value until the next window completes; the working register SHALL NOT alter packed_out mid-window.
REQ-028 Back-to-back windows SHALL be accepted without bubbles: a transfer is allowed in the cycle data_valid_out is high.
REQ-029 win_cnt SHALL increment on each window completion.
REQ-030 On completion of window NUM_WINDOWS-1, the FSM SHALL move FILL->DRAIN.
REQ-031 DRAIN SHALL count exactly DRAIN_CYCLES cycles, then move to DONE.
REQ-032 DONE SHALL assert end_flag for one cycle and return to IDLE on the next edge.
REQ-033 end_flag SHALL never coincide with data_valid_out.
REQ-034 Gaps in in_valid during FILL SHALL stall elem_cnt and leave partial-window contents unchanged.

Reset
REQ-035 While reset=0, the FSM SHALL be IDLE, elem_cnt, win_cnt, the drain counter, the working register and packed_out SHALL be 0, and in_ready, data_valid_out, end_flag and busy SHALL be 0.
REQ-036 Reset asserted mid-window or mid-drain SHALL discard partial data and suppress any pending data_valid_out and end_flag.

Verification
REQ-037 Single window: NUM_WINDOWS=1, start, 27 transfers pixel=256, weight=256 -> every slot 0x100, data_valid_out one cycle after the 27th transfer, end_flag exactly 8 cycles after the data_valid_out cycle, busy low afterwards.
REQ-038 Rounding ties: (pixel=1, weight=128) -> 0; (pixel=3, weight=128) -> 2; (pixel=-1, weight=128) -> 0; (pixel=-3, weight=128) -> -2.
REQ-039 Saturation: (pixel=8191, weight=8191) -> 8191; (pixel=-8192, weight=8191) -> -8192; (pixel=-8192, weight=-8192) -> 8191.
REQ-040 Streaming: NUM_WINDOWS=3, in_valid held high -> data_valid_out pulses 27 cycles apart, in_ready never drops in FILL, slot k of window w equals element w*27+k.
REQ-041 Stalls and start: random in_valid gaps -> identical packed_out to the gap-free run; start pulsed during FILL -> no effect.
REQ-042 Reset mid-op: reset=0 after 10 transfers -> all outputs 0; a new run after release completes correctly with elem_cnt starting at 0.
